// File: rtl/commit_trace_serializer.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_serializer
// Purpose  : Packs ROB commits into fixed-size little-endian trace records,
//            buffers them in a small FIFO and streams them out byte by byte.
//            Define TRACE_CHECKSUM_EN to append an XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_serializer #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic [4:0]  commit_rd,
   input  logic        commit_we,
   input  logic [31:0] commit_data,
   output logic        out_valid,
   output logic [7:0]  out_byte,
   output logic        out_last,
   input  logic        out_ready,
   output logic        overflow,
   output logic [15:0] drop_count
);

`ifdef TRACE_CHECKSUM_EN
   localparam int c_REC_BYTES = 10;
`else
   localparam int c_REC_BYTES = 9;
`endif
   localparam int               c_REC_W    = c_REC_BYTES * 8;
   localparam int               c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0]    c_DEPTH    = (c_AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]       c_LAST_IDX = 4'(c_REC_BYTES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_REC_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]      r_wr_ptr;
   logic [c_AW-1:0]      r_rd_ptr;
   logic [c_AW:0]        r_count;
   logic [c_REC_W-1:0]   r_shift;
   logic [3:0]           r_byte_idx;
   logic                 r_overflow;
   logic [15:0]          r_drop_count;

   logic                 w_not_empty;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_last;
   logic [7:0]           w_hdr;
   logic [31:0]          w_data;
   logic [c_REC_W-1:0]   w_rec;

   assign w_hdr  = {commit_we, 2'b00, commit_rd};
   assign w_data = commit_we ? commit_data : 32'h0;

`ifdef TRACE_CHECKSUM_EN
   logic [7:0] w_csum;
   assign w_csum = commit_pc[7:0] ^ commit_pc[15:8] ^ commit_pc[23:16] ^ commit_pc[31:24]
                 ^ w_hdr ^ w_data[7:0] ^ w_data[15:8] ^ w_data[23:16] ^ w_data[31:24];
   assign w_rec  = {w_csum, w_data, w_hdr, commit_pc};
`else
   assign w_rec  = {w_data, w_hdr, commit_pc};
`endif

   assign w_not_empty = (r_count != '0);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign w_push = commit_valid && ((r_count != c_DEPTH) || w_pop);
   assign w_drop = commit_valid && !w_push;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_not_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            w_last = (r_byte_idx == c_LAST_IDX);
            if (out_ready && w_last) begin
               if (w_not_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_shift      <= '0;
         r_byte_idx   <= 4'd0;
         r_overflow   <= 1'b0;
         r_drop_count <= 16'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
         if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_byte_idx <= 4'd0;
         end else if ((r_state == S_SEND) && out_ready && !w_last) begin
            r_shift    <= r_shift >> 8;
            r_byte_idx <= r_byte_idx + 4'd1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
               r_drop_count <= r_drop_count + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && w_push) begin
         r_mem[r_wr_ptr] <= w_rec;
      end
   end

   assign out_valid  = (r_state == S_SEND);
   assign out_byte   = out_valid ? r_shift[7:0] : 8'h00;
   assign out_last   = w_last;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_serializer
// Purpose  : Directed self-checking bench for commit_trace_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_serializer;

`ifdef TRACE_CHECKSUM_EN
   localparam int REC = 10;
`else
   localparam int REC = 9;
`endif
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic [4:0]  commit_rd;
   logic        commit_we;
   logic [31:0] commit_data;
   logic        out_valid;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        out_ready;
   logic        overflow;
   logic [15:0] drop_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [8:0] q[$];
   int         qt[$];

   commit_trace_serializer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_rd    (commit_rd),
      .commit_we    (commit_we),
      .commit_data  (commit_data),
      .out_valid    (out_valid),
      .out_byte     (out_byte),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Accepted bytes are captured mid-cycle, when the handshake inputs are settled.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         q.push_back({out_last, out_byte});
         qt.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte 0 in bits [7:0]; checksum byte in [79:72].
   function automatic logic [79:0] mkrec(input logic [31:0] pc, input logic [4:0] rd,
                                         input logic we, input logic [31:0] d);
      logic [31:0] dd;
      logic [7:0]  h;
      logic [7:0]  ck;
      dd = we ? d : 32'h0;
      h  = {we, 2'b00, rd};
      ck = pc[7:0] ^ pc[15:8] ^ pc[23:16] ^ pc[31:24] ^ h
         ^ dd[7:0] ^ dd[15:8] ^ dd[23:16] ^ dd[31:24];
      return {ck, dd, h, pc};
   endfunction

   task automatic commit(input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic [31:0] d);
      commit_valid = 1'b1;
      commit_pc    = pc;
      commit_rd    = rd;
      commit_we    = we;
      commit_data  = d;
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int limit);
      for (int i = 0; i < limit && q.size() < n; i++) tick();
      check("drain_bytes", 32'(q.size() >= n), 32'd1);
   endtask

   task automatic wait_valid(input int limit);
      for (int i = 0; i < limit && !out_valid; i++) tick();
      check("wait_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic expect_rec(input string tag, input logic [79:0] exp);
      for (int i = 0; i < REC; i++) begin
         logic [8:0] e;
         logic [8:0] got;
         e = {(i == REC - 1), exp[8*i +: 8]};
         if (q.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
         end else begin
            got = q.pop_front();
            void'(qt.pop_front());
            check(tag, 32'(got), 32'(e));
         end
      end
   endtask

   initial begin
      logic [79:0] exp1;
      logic [79:0] exp2;
      logic [8:0]  cur;
      logic [8:0]  prev;
      int          span;

      exp1 = 80'hBF_00_00_00_2A_85_00_00_00_10;
      exp2 = 80'h02_00_00_00_00_03_00_00_01_00;

      rst = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_rd = '0;
      commit_we = 1'b0; commit_data = '0; out_ready = 1'b1;
      #1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_byte", 32'(out_byte), 32'h00);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);

      // Idle-path latency and the basic write record
      commit(32'h0000_0010, 5'd5, 1'b1, 32'h0000_002A);
      check("lat_not_yet", 32'(out_valid), 32'd0);
      tick();
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_b0", 32'(out_byte), 32'h10);
      wait_bytes(REC, 40);
      expect_rec("rec_write", exp1);

      // Non-writing commit zeroes the data bytes
      commit(32'h0000_0100, 5'd3, 1'b0, 32'hDEAD_BEEF);
      wait_bytes(REC, 40);
      expect_rec("rec_nowrite", exp2);

      // Backpressure: ready alternates 1/0, stalled bytes must hold
      out_ready = 1'b0;
      commit(32'h1234_5678, 5'd31, 1'b1, 32'hCAFE_F00D);
      wait_valid(20);
      prev = '0;
      for (int k = 0; k < 2 * REC - 1; k++) begin
         out_ready = (k % 2 == 0);
         cur = {out_last, out_byte};
         if (k % 2 == 0 && k > 0) check("bp_hold", 32'(cur), 32'(prev));
         prev = cur;
         tick();
      end
      out_ready = 1'b0;
      check("bp_done", 32'(out_valid), 32'd0);
      check("bp_count", 32'(q.size()), 32'(REC));
      expect_rec("rec_bp", mkrec(32'h1234_5678, 5'd31, 1'b1, 32'hCAFE_F00D));
      out_ready = 1'b1;

      // Burst of three: no bubble between records
      commit(32'h0000_2000, 5'd1, 1'b1, 32'h1111_1111);
      commit(32'h0000_2004, 5'd2, 1'b0, 32'h2222_2222);
      commit(32'h0000_2008, 5'd3, 1'b1, 32'h8000_0001);
      wait_bytes(3 * REC, 80);
      span = (qt.size() >= 3 * REC) ? qt[3 * REC - 1] - qt[0] : -1;
      check("burst_span", 32'(span), 32'(3 * REC - 1));
      expect_rec("burst0", mkrec(32'h0000_2000, 5'd1, 1'b1, 32'h1111_1111));
      expect_rec("burst1", mkrec(32'h0000_2004, 5'd2, 1'b0, 32'h2222_2222));
      expect_rec("burst2", mkrec(32'h0000_2008, 5'd3, 1'b1, 32'h8000_0001));

      // Overflow: 11 commits against a stalled sink
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         commit(32'h0000_1000 + 32'(4 * i), 5'(i), 1'(i), 32'(i) * 32'h0101_0101);
         if (i == DEPTH) check("ovf_before", 32'(overflow), 32'd0);
         if (i == DEPTH + 1) begin
            check("ovf_first", 32'(overflow), 32'd1);
            check("ovf_first_cnt", 32'(drop_count), 32'd1);
         end
      end
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_drop_count", 32'(drop_count), 32'd2);
      check("ovf_no_accept", 32'(q.size()), 32'd0);
      out_ready = 1'b1;
      wait_bytes((DEPTH + 1) * REC, 200);
      for (int i = 0; i < DEPTH + 1; i++)
         expect_rec("ovf_rec", mkrec(32'h0000_1000 + 32'(4 * i), 5'(i), 1'(i), 32'(i) * 32'h0101_0101));
      repeat (5) tick();
      check("ovf_no_extra", 32'(q.size()), 32'd0);
      check("ovf_idle", 32'(out_valid), 32'd0);

      // Reset mid-record with a second record queued
      commit(32'h0000_0010, 5'd5, 1'b1, 32'h0000_002A);
      commit(32'h0000_3000, 5'd7, 1'b1, 32'h5555_AAAA);
      wait_valid(20);
      repeat (4) tick();
      check("mid_b0_b3", 32'(q.size()), 32'd4);
      rst = 1'b0;
      tick();
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_byte", 32'(out_byte), 32'h00);
      check("mid_rst_drop", 32'(drop_count), 32'd0);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b1;
      q.delete();
      qt.delete();
      repeat (10) tick();
      check("mid_fifo_empty", 32'({out_valid, 8'(q.size())}), 32'd0);
      commit(32'h0000_0100, 5'd3, 1'b0, 32'hDEAD_BEEF);
      wait_bytes(REC, 40);
      expect_rec("post_rst_rec", exp2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
